// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, the imem request handshake and the
// IF/ID register. Supports stall (one-entry hold buffer) and redirect/flush with kill.
module if_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              ifid_valid,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_pc4
);

  localparam logic [0:0]        ST_FETCH = 1'b0;
  localparam logic [0:0]        ST_HOLD  = 1'b1;
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(32'd4);

  logic [0:0]        r_state;
  logic              r_req;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_kill;
  logic [ADDR_W-1:0] r_pending_pc;
  logic [31:0]       r_hold_instr;
  logic [ADDR_W-1:0] r_hold_pc;
  logic              r_ifid_valid;
  logic [31:0]       r_ifid_instr;
  logic [ADDR_W-1:0] r_ifid_pc;
  logic [ADDR_W-1:0] r_ifid_pc4;

  logic [0:0]        w_state_nxt;
  logic              w_req_nxt;
  logic [ADDR_W-1:0] w_fetch_pc_nxt;
  logic              w_kill_nxt;
  logic [ADDR_W-1:0] w_pending_pc_nxt;
  logic [31:0]       w_hold_instr_nxt;
  logic [ADDR_W-1:0] w_hold_pc_nxt;
  logic              w_ifid_valid_nxt;
  logic [31:0]       w_ifid_instr_nxt;
  logic [ADDR_W-1:0] w_ifid_pc_nxt;
  logic [ADDR_W-1:0] w_ifid_pc4_nxt;
  logic [ADDR_W-1:0] w_fetch_pc_inc;
  logic [ADDR_W-1:0] w_hold_pc_inc;

  assign w_fetch_pc_inc = r_fetch_pc + PC_STEP;
  assign w_hold_pc_inc  = r_hold_pc + PC_STEP;

  // Next-state logic; redirect (flush) outranks stall and everything else.
  always_comb begin
    w_state_nxt      = r_state;
    w_req_nxt        = r_req;
    w_fetch_pc_nxt   = r_fetch_pc;
    w_kill_nxt       = r_kill;
    w_pending_pc_nxt = r_pending_pc;
    w_hold_instr_nxt = r_hold_instr;
    w_hold_pc_nxt    = r_hold_pc;
    w_ifid_valid_nxt = r_ifid_valid;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_pc4_nxt   = r_ifid_pc4;

    if (redirect_valid) begin
      w_ifid_valid_nxt = 1'b0;
      if (r_req && !imem_ack) begin
        // Address must stay put until the in-flight word returns; remember where to go.
        w_kill_nxt       = 1'b1;
        w_pending_pc_nxt = redirect_pc;
      end else begin
        w_fetch_pc_nxt = redirect_pc;
        w_kill_nxt     = 1'b0;
        w_state_nxt    = ST_FETCH;
        w_req_nxt      = 1'b1;
      end
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (!stall) begin
            w_ifid_valid_nxt = 1'b1;
            w_ifid_instr_nxt = r_hold_instr;
            w_ifid_pc_nxt    = r_hold_pc;
            w_ifid_pc4_nxt   = w_hold_pc_inc;
            w_fetch_pc_nxt   = w_hold_pc_inc;
            w_state_nxt      = ST_FETCH;
            w_req_nxt        = 1'b1;
          end else begin
            w_ifid_valid_nxt = r_ifid_valid;
          end
        end
        ST_FETCH: begin
          if (!r_req) begin
            w_req_nxt        = 1'b1;
            w_ifid_valid_nxt = stall ? r_ifid_valid : 1'b0;
          end else if (imem_ack) begin
            if (r_kill) begin
              w_fetch_pc_nxt   = r_pending_pc;
              w_kill_nxt       = 1'b0;
              w_ifid_valid_nxt = stall ? r_ifid_valid : 1'b0;
            end else if (stall) begin
              w_hold_instr_nxt = imem_rdata;
              w_hold_pc_nxt    = r_fetch_pc;
              w_state_nxt      = ST_HOLD;
              w_req_nxt        = 1'b0;
            end else begin
              w_ifid_valid_nxt = 1'b1;
              w_ifid_instr_nxt = imem_rdata;
              w_ifid_pc_nxt    = r_fetch_pc;
              w_ifid_pc4_nxt   = w_fetch_pc_inc;
              w_fetch_pc_nxt   = w_fetch_pc_inc;
            end
          end else begin
            w_ifid_valid_nxt = stall ? r_ifid_valid : 1'b0;
          end
        end
        default: begin
          w_state_nxt      = ST_FETCH;
          w_req_nxt        = 1'b0;
          w_kill_nxt       = 1'b0;
          w_ifid_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_FETCH;
      r_req        <= 1'b0;
      r_fetch_pc   <= RESET_PC;
      r_kill       <= 1'b0;
      r_pending_pc <= '0;
      r_hold_instr <= 32'h0000_0000;
      r_hold_pc    <= '0;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= 32'h0000_0000;
      r_ifid_pc    <= '0;
      r_ifid_pc4   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_req        <= w_req_nxt;
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_kill       <= w_kill_nxt;
      r_pending_pc <= w_pending_pc_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_pc4   <= w_ifid_pc4_nxt;
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_fetch_pc;
  assign ifid_valid = r_ifid_valid;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_pc4   = r_ifid_pc4;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: bench-side memory, directed scenarios plus random
// stall/redirect traffic, checked by a program-order scoreboard.
module tb_if_stage;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clock, reset, stall, redirect_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, ifid_instr, ifid_pc, ifid_pc4;
  logic        imem_req, imem_ack, ifid_valid;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_next;
  int lat_fixed, cur_lat, cnt;
  bit force_stale;
  bit last_st, last_rd, mdl_valid;
  logic [31:0] mdl_pc;

  if_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int new_lat();
    return (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 2));
  endfunction

  // Program order: delivered PCs run sequentially from the last reset/redirect target.
  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(model_next);
      model_next = model_next + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    model_next = pc;
    refill();
  endtask

  // One clock: drive control + memory response, take the edge, update the model.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    bit          req_now, ack_now;
    logic [31:0] addr_now;
    req_now  = imem_req;
    addr_now = imem_addr;
    stall = st; redirect_valid = rd; redirect_pc = rpc;
    if (req_now) begin
      ack_now    = (cnt >= cur_lat);
      imem_ack   = ack_now;
      imem_rdata = addr_now ^ KEY;
    end else begin
      ack_now    = 1'b0;
      imem_ack   = force_stale ? 1'b1 : ($urandom_range(0, 3) == 0);
      imem_rdata = 32'hBAD0_0000 | ($urandom & 32'h0000_FFFF);
    end
    @(posedge clock);
    if (req_now && ack_now) begin
      cnt = 0;
      cur_lat = new_lat();
    end else if (req_now) begin
      cnt++;
    end else begin
      cnt = 0;
    end
    if (rd) restart(rpc);
    else refill();
    #1;
    if (req_now && !ack_now) begin
      chk("addr_stable_req", 32'(imem_req), 32'd1);
      chk("addr_stable", imem_addr, addr_now);
    end
  endtask

  task automatic release_reset();
    reset = 1'b1;
    cnt = 0;
    cur_lat = new_lat();
    restart(32'h0000_0000);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
    @(posedge clock);
    #1;
    release_reset();
  endtask

  // Monitor: evaluates the outputs of the edge just passed against the scoreboard.
  always @(negedge clock) begin : mon
    logic [31:0] e;
    if (!reset) begin
      chk("rst_valid", 32'(ifid_valid), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_instr", ifid_instr, 32'd0);
      chk("rst_pc", ifid_pc, 32'd0);
      chk("rst_pc4", ifid_pc4, 32'd0);
      last_st = 1'b0; last_rd = 1'b0; mdl_valid = 1'b0;
    end else begin
      if (last_rd) begin
        chk("flush_valid", 32'(ifid_valid), 32'd0);
        mdl_valid = 1'b0;
      end else if (last_st) begin
        chk("hold_valid", 32'(ifid_valid), 32'(mdl_valid));
        if (mdl_valid) begin
          chk("hold_pc", ifid_pc, mdl_pc);
          chk("hold_instr", ifid_instr, mdl_pc ^ KEY);
        end
      end else if (ifid_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL deliver_unexpected: got pc %h expected no delivery", ifid_pc);
        end else begin
          e = exp_q.pop_front();
          chk("deliver_pc", ifid_pc, e);
          chk("deliver_instr", ifid_instr, e ^ KEY);
          chk("deliver_pc4", ifid_pc4, e + 32'd4);
          mdl_valid = 1'b1;
          mdl_pc = e;
        end
      end else begin
        mdl_valid = 1'b0;
      end
      last_st = stall;
      last_rd = redirect_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0; lat_fixed = 0; cur_lat = 0; cnt = 0;
    force_stale = 1'b0; mdl_valid = 1'b0; mdl_pc = 32'd0; last_st = 1'b0; last_rd = 1'b0;
    model_next = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    release_reset();

    // Zero-wait memory: one instruction per cycle.
    chk("t1_req_idle", 32'(imem_req), 32'd0);
    step(1'b0, 1'b0, 32'd0);
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", imem_addr, 32'd0);
    for (int k = 2; k <= 5; k++) begin
      step(1'b0, 1'b0, 32'd0);
      chk("t1_valid", 32'(ifid_valid), 32'd1);
      chk("t1_pc", ifid_pc, 32'(4 * (k - 2)));
    end

    // Two-cycle latency: one instruction every third cycle.
    lat_fixed = 2;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0, 32'd0);
      chk("t2_valid", 32'(ifid_valid), (k >= 4 && (k - 4) % 3 == 0) ? 32'd1 : 32'd0);
      if (k >= 4 && k <= 6) chk("t2_addr", imem_addr, 32'h4);
    end

    // Stall coincident with the ack of 0x8.
    lat_fixed = 0;
    do_reset();
    for (int n = 0; n < 20 && !(imem_req && imem_addr == 32'h8); n++) step(1'b0, 1'b0, 32'd0);
    chk("t3_reach8", imem_addr, 32'h8);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 32'd0);
      chk("t3_hold_req", 32'(imem_req), 32'd0);
      chk("t3_hold_pc", ifid_pc, 32'h4);
    end
    step(1'b0, 1'b0, 32'd0);
    chk("t3_rel_valid", 32'(ifid_valid), 32'd1);
    chk("t3_rel_pc", ifid_pc, 32'h8);
    chk("t3_next_addr", imem_addr, 32'hC);

    // Redirect during a wait on 0x10 (kill).
    lat_fixed = 2;
    do_reset();
    for (int n = 0; n < 40 && !(imem_req && imem_addr == 32'h10); n++) step(1'b0, 1'b0, 32'd0);
    chk("t4_reach10", imem_addr, 32'h10);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h100);
    chk("t4_flush", 32'(ifid_valid), 32'd0);
    chk("t4_addr_kept", imem_addr, 32'h10);
    for (int n = 0; n < 10 && imem_addr != 32'h100; n++) step(1'b0, 1'b0, 32'd0);
    chk("t4_addr_new", imem_addr, 32'h100);
    for (int n = 0; n < 10 && !ifid_valid; n++) step(1'b0, 1'b0, 32'd0);
    chk("t4_pc_new", ifid_pc, 32'h100);

    // Redirect in the same cycle as ack, with stall.
    lat_fixed = 0;
    do_reset();
    for (int n = 0; n < 10 && !ifid_valid; n++) step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h200);
    chk("t5_flush", 32'(ifid_valid), 32'd0);
    chk("t5_req", 32'(imem_req), 32'd1);
    chk("t5_addr", imem_addr, 32'h200);
    for (int n = 0; n < 10 && !ifid_valid; n++) step(1'b0, 1'b0, 32'd0);
    chk("t5_pc", ifid_pc, 32'h200);

    // Reset mid-wait, then a stale ack while imem_req is low.
    lat_fixed = 2;
    do_reset();
    for (int n = 0; n < 20 && !(imem_req && imem_addr == 32'h4); n++) step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_req", 32'(imem_req), 32'd0);
    chk("t6_valid", 32'(ifid_valid), 32'd0);
    chk("t6_instr", ifid_instr, 32'd0);
    chk("t6_pc", ifid_pc, 32'd0);
    chk("t6_pc4", ifid_pc4, 32'd0);
    chk("t6_addr", imem_addr, 32'd0);
    imem_ack = 1'b0;
    @(posedge clock);
    #1;
    release_reset();
    force_stale = 1'b1;
    step(1'b0, 1'b0, 32'd0);
    force_stale = 1'b0;
    chk("t6_first_req", 32'(imem_req), 32'd1);
    chk("t6_first_addr", imem_addr, 32'd0);
    chk("t6_stale_valid", 32'(ifid_valid), 32'd0);
    for (int n = 0; n < 10 && !ifid_valid; n++) step(1'b0, 1'b0, 32'd0);
    chk("t6_deliver_pc", ifid_pc, 32'd0);
    chk("t6_deliver_instr", ifid_instr, KEY);

    // PC wrap.
    lat_fixed = 0;
    do_reset();
    for (int n = 0; n < 10 && !ifid_valid; n++) step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("t7_addr", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'd0);
    chk("t7_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("t7_pc4", ifid_pc4, 32'h0000_0000);
    chk("t7_next_addr", imem_addr, 32'h0000_0000);
    step(1'b0, 1'b0, 32'd0);
    chk("t7_wrapped_pc", ifid_pc, 32'h0000_0000);

    // Random stall/redirect/latency traffic.
    lat_fixed = -1;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom & 32'hFFFF_FFFC);
    end
    repeat (3) step(1'b0, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
